// File: rtl/cas_pkg.sv
// ---------------------------------------------------------------------------
// cas_pkg -- shared types and timing helpers for the cassette player.
//
// Holds the playback FSM state type, the three cassette line levels and the
// per-speed cell/pulse timing table. The timing helpers are only evaluated
// with constant arguments, so every division happens at elaboration time.
// ---------------------------------------------------------------------------
package cas_pkg;

    // Width of the in-cell cycle counter; covers cells up to 16M clocks.
    localparam int TIME_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CELL,
        DONE
    } state_t;

    localparam logic [1:0] LVL_IDLE = 2'b01;
    localparam logic [1:0] LVL_POS  = 2'b10;
    localparam logic [1:0] LVL_NEG  = 2'b00;

    // Edges inside one bit cell, all relative to the cell start:
    //   [0,p1) pos, [p1,p2) neg, [h0,h1) data pos, [h1,h2) data neg.
    typedef struct packed {
        logic [TIME_W-1:0] last;
        logic [TIME_W-1:0] p1;
        logic [TIME_W-1:0] p2;
        logic [TIME_W-1:0] h0;
        logic [TIME_W-1:0] h1;
        logic [TIME_W-1:0] h2;
    } timing_t;

    // Scale a 1x clock count to the selected CPU speed (1x, 1.5x, 2x, 12x).
    // Rounds down, never below one clock, so very short pulses survive 12x.
    function automatic int unsigned scale_clks(input int unsigned base,
                                               input int unsigned sel);
        int unsigned v;
        case (sel)
            0:       v = base;
            1:       v = (base * 2) / 3;
            2:       v = base / 2;
            default: v = base / 12;
        endcase
        return (v == 0) ? 1 : v;
    endfunction

    function automatic timing_t make_timing(input int unsigned cell_clks,
                                            input int unsigned pulse_clks,
                                            input int unsigned sel);
        timing_t     tm;
        int unsigned c;
        int unsigned p;
        int unsigned h;
        c       = scale_clks(cell_clks, sel);
        p       = scale_clks(pulse_clks, sel);
        h       = c / 2;
        tm.last = TIME_W'(c - 1);
        tm.p1   = TIME_W'(p);
        tm.p2   = TIME_W'(2 * p);
        tm.h0   = TIME_W'(h);
        tm.h1   = TIME_W'(h + p);
        tm.h2   = TIME_W'(h + 2 * p);
        return tm;
    endfunction

    // Line level at cycle t of a cell: a clock pulse at the start, and a
    // second pulse at mid-cell only when the data bit is 1.
    function automatic logic [1:0] cell_level(input logic [TIME_W-1:0] t,
                                              input timing_t           tm,
                                              input logic              data_bit);
        logic [1:0] lvl;
        lvl = LVL_IDLE;
        if (t < tm.p1) begin
            lvl = LVL_POS;
        end else if (t < tm.p2) begin
            lvl = LVL_NEG;
        end else if (t >= tm.h0 && t < tm.h1) begin
            lvl = data_bit ? LVL_POS : LVL_IDLE;
        end else if (t >= tm.h1 && t < tm.h2) begin
            lvl = data_bit ? LVL_NEG : LVL_IDLE;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/cas_buffer.sv
// ---------------------------------------------------------------------------
// cas_buffer -- 2^ADDR_W x 8 byte store for the captured .CAS image.
//
// One write port and one registered read port on the same clock, written
// in the shape synthesis maps onto a block RAM.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write byte
//   raddr  : read address, sampled every clock
//   rdata  : byte at raddr, one clock later
// ---------------------------------------------------------------------------
module cas_buffer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // NOTE: the array and its read register get no reset; a reset would
    // stop the storage from mapping onto block RAM, and the image is always
    // written before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cas_player.sv
// ---------------------------------------------------------------------------
// cas_player -- captures a .CAS image from the download stream and replays
// it as TRS-80 Level II 500-baud FM pulses while the cassette motor is on.
//
//   clk_sys   : system clock, also clocks the download port
//   reset_n   : asynchronous active-low reset
//   dn_go     : download active; its rising edge clears the image
//   dn_wr     : one-cycle download byte strobe
//   dn_addr   : download address, bit 16 selects the cassette region
//   dn_data   : download byte
//   motor     : cassette motor relay from the core
//   rewind    : one-cycle pulse, back to byte 0
//   speed     : CPU speed select (1x, 1.5x, 2x, 12x)
//   cas_level : 01 idle, 10 positive half, 00 negative half
//   playing   : high while fetching or emitting a cell
//   done      : high once the last bit of the last byte has been sent
//   pos       : index of the byte currently playing
// ---------------------------------------------------------------------------
module cas_player
    import cas_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int CELL_CLKS  = 84000,
    parameter int PULSE_CLKS = 4200
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dn_go,
    input  logic              dn_wr,
    input  logic [16:0]       dn_addr,
    input  logic [7:0]        dn_data,
    input  logic              motor,
    input  logic              rewind,
    input  logic [1:0]        speed,
    output logic [1:0]        cas_level,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] pos
);

    localparam timing_t TIM_1X   = make_timing(CELL_CLKS, PULSE_CLKS, 0);
    localparam timing_t TIM_1_5X = make_timing(CELL_CLKS, PULSE_CLKS, 1);
    localparam timing_t TIM_2X   = make_timing(CELL_CLKS, PULSE_CLKS, 2);
    localparam timing_t TIM_12X  = make_timing(CELL_CLKS, PULSE_CLKS, 3);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   length;          // one wider: a full buffer is 2^ADDR_W
    logic [ADDR_W:0]   length_next;
    logic [ADDR_W:0]   wr_len;
    logic [ADDR_W-1:0] pos_next;
    logic [7:0]        shift;           // current bit is always shift[7]
    logic [7:0]        shift_next;
    logic [7:0]        rdata;
    logic [2:0]        bit_idx;         // bits still to send after this one
    logic [2:0]        bit_idx_next;
    logic [TIME_W-1:0] t;
    logic [TIME_W-1:0] t_next;
    timing_t           tim;             // timing frozen for the running cell
    timing_t           tim_next;
    timing_t           tim_sel;
    logic              dn_go_d;
    logic              dn_rise;
    logic              cap_wr;
    logic              last_byte;
    logic              cell_end;

    assign dn_rise   = dn_go & ~dn_go_d;
    assign cap_wr    = dn_go & dn_wr & dn_addr[16];
    assign wr_len    = {1'b0, dn_addr[ADDR_W-1:0]} + LEN_ONE;
    assign last_byte = ({1'b0, pos} + LEN_ONE) == length;
    assign cell_end  = (t == tim.last);

    // The read address follows the next byte index, so the byte is already
    // in rdata during the single FETCH cycle.
    cas_buffer #(
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk   (clk_sys),
        .we    (cap_wr),
        .waddr (dn_addr[ADDR_W-1:0]),
        .wdata (dn_data),
        .raddr (pos_next),
        .rdata (rdata)
    );

    always_comb begin
        case (speed)
            2'd0:    tim_sel = TIM_1X;
            2'd1:    tim_sel = TIM_1_5X;
            2'd2:    tim_sel = TIM_2X;
            default: tim_sel = TIM_12X;
        endcase
    end

    // Image length tracks the highest byte written since the last download
    // started.
    // NOTE: every variable written in an always_comb block gets a value
    // before any branch; a path that skips one would infer a latch.
    always_comb begin
        length_next = dn_rise ? '0 : length;
        if (cap_wr && wr_len > length_next) begin
            length_next = wr_len;
        end
    end

    always_comb begin
        next_state   = state;
        pos_next     = pos;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        t_next       = t;
        tim_next     = tim;

        // A new download wins over rewind; both abort playback.
        if (dn_rise || rewind) begin
            next_state   = IDLE;
            pos_next     = '0;
            bit_idx_next = 3'd7;
            t_next       = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (motor && !dn_go && ({1'b0, pos} < length)) begin
                        next_state = FETCH;
                    end
                end

                FETCH: begin
                    // After a motor stop mid-byte the shift register still
                    // holds the remaining bits, so only reload on a new byte.
                    if (bit_idx == 3'd7) begin
                        shift_next = rdata;
                    end
                    tim_next   = tim_sel;
                    t_next     = '0;
                    next_state = CELL;
                end

                CELL: begin
                    if (!cell_end) begin
                        t_next = t + 1'b1;
                    end else begin
                        t_next = '0;
                        if (bit_idx == 3'd0) begin
                            bit_idx_next = 3'd7;
                            if (last_byte) begin
                                next_state = DONE;
                            end else begin
                                pos_next   = pos + 1'b1;
                                next_state = motor ? FETCH : IDLE;
                            end
                        end else begin
                            shift_next   = {shift[6:0], 1'b0};
                            bit_idx_next = bit_idx - 3'd1;
                            if (motor) begin
                                tim_next = tim_sel;
                            end else begin
                                next_state = IDLE;
                            end
                        end
                    end
                end

                default: begin
                    // DONE holds until rewind or a new download.
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pos     <= '0;
            length  <= '0;
            shift   <= '0;
            bit_idx <= 3'd7;
            t       <= '0;
            tim     <= TIM_1X;
            dn_go_d <= 1'b0;
        end else begin
            state   <= next_state;
            pos     <= pos_next;
            length  <= length_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            t       <= t_next;
            tim     <= tim_next;
            dn_go_d <= dn_go;
        end
    end

    always_comb begin
        cas_level = LVL_IDLE;
        if (state == CELL) begin
            cas_level = cell_level(t, tim, shift[7]);
        end
        playing = (state == FETCH) || (state == CELL);
        done    = (state == DONE);
    end

endmodule

// File: doc/cas_player.md
Name: cas_player

Overview:
- Cassette playback engine placed between the HPS download path and the ht1080z core's cassette input.
- Captures a .CAS image from the download stream (cassette region, dn_addr[16]=1) into an internal byte buffer.
- While the emulated cassette motor is on, replays the image as TRS-80 Level II 500-baud FM pulses on a 2-bit cassette level.
- Cell timing scales with the selected CPU clock so the ROM's timing loops still decode it.

Parameters:
ADDR_W, 16, buffer address width; capacity 2^ADDR_W bytes
CELL_CLKS, 84000, bit-cell length in clk_sys cycles at 1x (2 ms at 42 MHz)
PULSE_CLKS, 4200, length of each pulse half in clk_sys cycles at 1x

Ports:
clk_sys  in  1  system clock (42 MHz); download port runs on same clock
reset_n  in  1  asynchronous, active-low reset
dn_go  in  1  download active
dn_wr  in  1  download byte strobe, one cycle
dn_addr  in  17  download address; bit16=1 selects cassette region
dn_data  in  8  download byte
motor  in  1  cassette motor relay from core
rewind  in  1  one-cycle pulse: pointer to 0, clear done
speed  in  2  0=1x, 1=1.5x, 2=2x, 3=12x; matches core overclock select
cas_level  out  2  2'b01 idle, 2'b10 positive half, 2'b00 negative half
playing  out  1  high while a cell is being emitted
done  out  1  high after last bit of last byte
pos  out  ADDR_W  index of byte currently playing

Behaviour:
- Reset (async, reset_n=0): cas_level=01, playing=0, done=0, pos=0, length=0, FSM=IDLE. Buffer contents undefined.
- Capture:
  - dn_wr with dn_go and dn_addr[16]=1 writes dn_data at dn_addr[ADDR_W-1:0].
  - length <= max(length, addr+1).
  - Rising edge of dn_go clears length, pos and done, and forces IDLE with cas_level=01, aborting any playback.
  - Writes with dn_addr[16]=0 are ignored.
- Effective timing: C = CELL_CLKS scaled by speed (x1, x2/3, x1/2, x1/12), P = PULSE_CLKS scaled the same way, H = C/2. All constants are precomputed; no runtime division.
- FSM states: IDLE, FETCH, CELL, DONE.
  - IDLE -> FETCH: when motor=1, dn_go=0, pos<length.
  - FETCH: buffer read of byte[pos] with 1-cycle latency. Byte loads into the shift register, bit count=7, then CELL.
  - CELL: a counter t runs 0..C-1.
    - t in [0,P): level 10.
    - t in [P,2P): level 00.
    - t in [H,H+P): level 10 if current bit=1, else 01.
    - t in [H+P,H+2P): level 00 if current bit=1, else 01.
    - All other t: level 01.
    - Bits are sent MSB first. At t=C-1, shift to the next bit. After bit 0, pos increments and the FSM goes to FETCH, or to DONE if pos+1==length.
  - DONE: done=1, cas_level=01. Leave only on rewind or a new download.
- Motor off in CELL: the current cell completes, then the FSM goes to IDLE with pos and bit index preserved. Motor on again resumes at the next bit.
- speed changes take effect at the next cell start.
- rewind in any state: pos=0, done=0, FSM=IDLE, level 01. If rewind and a dn_go rise occur in the same cycle, the download clear wins.
- playing=1 in FETCH and CELL.
- length=0 with motor=1: stay in IDLE; done stays 0.
- pos==2^ADDR_W-1 being the last byte: no wrap, go to DONE.

Decomposition:
- Package cas_pkg:
  - state enum (IDLE, FETCH, CELL, DONE)
  - level constants LVL_IDLE, LVL_POS, LVL_NEG
  - per-speed CELL/PULSE constant function or arrays
- One sub-module, cas_buffer: single-port-write / registered-read byte RAM, 2^ADDR_W x 8, inferred block RAM.

Test Plan:
(All scenarios use CELL_CLKS=48, PULSE_CLKS=4, speed=0.)
- Load bytes A5,00 at dn_addr 10000/10001, then motor=1:
  - cell 0 (bit 1) shows 10 x4, 00 x4, 01 to t=24, 10 x4, 00 x4, 01 to 47;
  - a 0-bit cell shows no mid-cell pulse;
  - 16 cells total, then done=1 and pos=1.
- Drop motor at t=10 of the third cell:
  - that cell completes, FSM goes IDLE, level 01;
  - motor back on: the fourth bit is emitted next, with total pulse count unchanged.
- speed=2: cell length 24 and pulse half 2 cycles; speed=3: cell 4, pulse 1 (rounded as the package table defines).
- Assert dn_go mid-playback: level 01 the next cycle, playing=0, length=0; new writes then play from pos 0.
- Assert rewind in DONE: done=0, pos=0; the image replays identically.
- reset_n low for 1 cycle mid-CELL: all outputs go to reset values immediately; motor=1 afterwards stays IDLE because length=0.
